// File: rtl/fixed_add_arbiter.sv
// Two-requester round-robin front end for one shared 8.23 fixed-point adder.
// Each accepted pair is added in a single cycle and returned on a tagged response channel.
module fixed_add_arbiter #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [INT_W-1:0]  req0_a_int,
    input  logic [INT_W-1:0]  req0_b_int,
    input  logic [FRAC_W-1:0] req0_a_frac,
    input  logic [FRAC_W-1:0] req0_b_frac,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [INT_W-1:0]  req1_a_int,
    input  logic [INT_W-1:0]  req1_b_int,
    input  logic [FRAC_W-1:0] req1_a_frac,
    input  logic [FRAC_W-1:0] req1_b_frac,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [INT_W-1:0]  rsp_int,
    output logic [FRAC_W-1:0] rsp_frac,
    output logic              rsp_ovf,
    output logic              busy
);

    localparam int W = INT_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic         last_grant;
    logic         grant;
    logic         accept;

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_id;
    logic [W-1:0] win_a;
    logic [W-1:0] win_b;
    logic [W:0]   sum_full;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign win_a = grant ? {req1_a_int, req1_a_frac} : {req0_a_int, req0_a_frac};
    assign win_b = grant ? {req1_b_int, req1_b_frac} : {req0_b_int, req0_b_frac};

    // Zero-extend so the carry out of the integer MSB lands in the top bit.
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = ISSUE;
            ISSUE:                  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic: ready only in IDLE, only for the winner, and never during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = rst_n && req0_valid && !grant;
                req1_ready = rst_n && req1_valid &&  grant;
            end
            ISSUE: ;
            RESP:  rsp_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Round-robin history; reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && accept) begin
            last_grant <= grant;
        end
    end

    // NOTE: operand registers carry no reset; they are always written on accept before ISSUE reads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            op_a  <= win_a;
            op_b  <= win_b;
            op_id <= grant;
        end
    end

    // Response registers load in ISSUE and hold through RESP until the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id   <= 1'b0;
            rsp_int  <= '0;
            rsp_frac <= '0;
            rsp_ovf  <= 1'b0;
        end else if (state == ISSUE) begin
            rsp_id   <= op_id;
            rsp_int  <= sum_full[W-1:FRAC_W];
            rsp_frac <= sum_full[FRAC_W-1:0];
            rsp_ovf  <= sum_full[W];
        end
    end

endmodule

// File: tb/tb_fixed_add_arbiter.sv
// Directed bench for fixed_add_arbiter: reset, single adds, round-robin,
// response backpressure and reset in the middle of an operation.
module tb_fixed_add_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a_int, req0_b_int, req1_a_int, req1_b_int;
    logic [22:0] req0_a_frac, req0_b_frac, req1_a_frac, req1_b_frac;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [7:0]  rsp_int;
    logic [22:0] rsp_frac;

    int n_cmp = 0;
    int n_bad = 0;

    fixed_add_arbiter #(.INT_W(8), .FRAC_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a_int (req0_a_int),
        .req0_b_int (req0_b_int),
        .req0_a_frac(req0_a_frac),
        .req0_b_frac(req0_b_frac),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a_int (req1_a_int),
        .req1_b_int (req1_b_int),
        .req1_a_frac(req1_a_frac),
        .req1_b_frac(req1_b_frac),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_int    (rsp_int),
        .rsp_frac   (rsp_frac),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a_int = 8'd1; req0_b_int = 8'd1; req0_a_frac = '0; req0_b_frac = '0;
        req1_a_int = 8'd2; req1_b_int = 8'd2; req1_a_frac = '0; req1_b_frac = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b, required 00", {req1_ready, req0_ready});
        end
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL reset_valid_busy: got %b, required 00", {rsp_valid, busy});
        end
        n_cmp++;
        if ({rsp_id, rsp_int, rsp_frac, rsp_ovf} !== 33'd0) begin
            n_bad++; $display("FAIL reset_rsp: got id=%0d int=%0d frac=%h ovf=%0d, required all zero",
                              rsp_id, rsp_int, rsp_frac, rsp_ovf);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single operation from requester 0 with rsp_ready held high.
    task automatic test_single_op(input string name,
                                  input logic [7:0] a_i, input logic [22:0] a_f,
                                  input logic [7:0] b_i, input logic [22:0] b_f,
                                  input logic [7:0] e_i, input logic [22:0] e_f, input logic e_o);
        req0_a_int = a_i; req0_a_frac = a_f; req0_b_int = b_i; req0_b_frac = b_f;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_bad++; $display("FAIL %s_ready: got %b, required 01", name, {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b1000) begin
            n_bad++; $display("FAIL %s_issue: got busy/valid/r0/r1=%b, required 1000", name,
                              {busy, rsp_valid, req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf} !== {1'b1, 1'b0, e_i, e_f, e_o}) begin
            n_bad++; $display("FAIL %s_rsp: got v=%0d id=%0d int=%0d frac=%h ovf=%0d, required v=1 id=0 int=%0d frac=%h ovf=%0d",
                              name, rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf, e_i, e_f, e_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL %s_done: got busy/valid=%b, required 00", name, {busy, rsp_valid});
        end
    endtask

    // Both requesters valid from reset: grants alternate 0,1,0,1 at one op per 3 cycles.
    task automatic test_round_robin();
        logic       e_id  [4];
        logic [7:0] e_int [4];
        logic [22:0] e_frac[4];
        e_id[0] = 1'b0; e_int[0] = 8'd11;  e_frac[0] = 23'h200000;
        e_id[1] = 1'b1; e_int[1] = 8'd120; e_frac[1] = 23'h000030;
        e_id[2] = 1'b0; e_int[2] = 8'd12;  e_frac[2] = 23'h200000;
        e_id[3] = 1'b1; e_int[3] = 8'd121; e_frac[3] = 23'h000030;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_a_int = 8'd1;   req0_a_frac = 23'h100000; req0_b_int = 8'd10; req0_b_frac = 23'h100000;
        req1_a_int = 8'd100; req1_a_frac = 23'h000010; req1_b_int = 8'd20; req1_b_frac = 23'h000020;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== (e_id[i] ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rr_grant%0d: got ready=%b, required grant %0d", i,
                                  {req1_ready, req0_ready}, e_id[i]);
            end
            @(negedge clk);
            if (e_id[i]) req1_a_int = req1_a_int + 8'd1;
            else         req0_a_int = req0_a_int + 8'd1;
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf} !== {1'b1, e_id[i], e_int[i], e_frac[i], 1'b0}) begin
                n_bad++; $display("FAIL rr_rsp%0d: got v=%0d id=%0d int=%0d frac=%h ovf=%0d, required id=%0d int=%0d frac=%h ovf=0",
                                  i, rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf, e_id[i], e_int[i], e_frac[i]);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Response held for 5 extra cycles; the next accept follows the handshake by one cycle.
    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req1_a_int = 8'd5; req1_a_frac = 23'h000001; req1_b_int = 8'd6; req1_b_frac = 23'h000002;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_bad++; $display("FAIL bp_grant: got ready=%b, required 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_a_int = 8'd7; req0_a_frac = '0; req0_b_int = 8'd8; req0_b_frac = '0;
        req0_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) begin
                rsp_ready = 1'b1;
                #1;
            end
            n_cmp++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_int, rsp_frac, rsp_ovf}
                !== {4'b1100, 1'b1, 8'd11, 23'h000003, 1'b0}) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%0d busy=%0d r0=%0d r1=%0d id=%0d int=%0d frac=%h ovf=%0d, required v=1 busy=1 r0=0 r1=0 id=1 int=11 frac=000003 ovf=0",
                                  c, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_int, rsp_frac, rsp_ovf);
            end
            if (c < 5) @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0010) begin
            n_bad++; $display("FAIL bp_next_accept: got busy/valid/r0/r1=%b, required 0010",
                              {busy, rsp_valid, req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL bp_next_issue: got busy=%0d, required 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf} !== {1'b1, 1'b0, 8'd15, 23'h0, 1'b0}) begin
            n_bad++; $display("FAIL bp_next_rsp: got v=%0d id=%0d int=%0d frac=%h ovf=%0d, required v=1 id=0 int=15 frac=0 ovf=0",
                              rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf);
        end
        @(negedge clk);
    endtask

    // Reset during ISSUE drops the pending op and restores requester 0 priority.
    task automatic test_reset_mid_op();
        rsp_ready = 1'b1;
        req0_a_int = 8'd3;  req0_a_frac = 23'h400000; req0_b_int = 8'd4;  req0_b_frac = 23'h400000;
        req1_a_int = 8'd50; req1_a_frac = '0;         req1_b_int = 8'd60; req1_b_frac = '0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_bad++; $display("FAIL mid_grant: got ready=%b, required 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_int, rsp_frac, rsp_ovf} !== 37'd0) begin
            n_bad++; $display("FAIL mid_reset_state: got v=%0d busy=%0d r0=%0d r1=%0d id=%0d int=%0d frac=%h ovf=%0d, required all zero",
                              rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_int, rsp_frac, rsp_ovf);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_bad++; $display("FAIL mid_regrant: got ready=%b, required 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b01) begin
            n_bad++; $display("FAIL mid_issue: got valid/busy=%b, required 01", {rsp_valid, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf} !== {1'b1, 1'b0, 8'd8, 23'h0, 1'b0}) begin
            n_bad++; $display("FAIL mid_rsp: got v=%0d id=%0d int=%0d frac=%h ovf=%0d, required v=1 id=0 int=8 frac=0 ovf=0",
                              rsp_valid, rsp_id, rsp_int, rsp_frac, rsp_ovf);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL mid_done: got valid/busy=%b, required 00", {rsp_valid, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single_op("basic", 8'd1, 23'h400000, 8'd2, 23'h200000, 8'd3, 23'h600000, 1'b0);
        test_single_op("frac_carry", 8'd0, 23'h7FFFFF, 8'd0, 23'h000001, 8'd1, 23'h000000, 1'b0);
        test_single_op("int_ovf", 8'd255, 23'h400000, 8'd1, 23'h400000, 8'd1, 23'h000000, 1'b1);
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
